// File: rtl/input_cond_pkg.sv
// Shared types for the input conditioner: debounce FSM state encoding.
package input_cond_pkg;

    typedef enum logic [1:0] {
        ST_LO     = 2'b00,
        ST_LO_CHK = 2'b01,
        ST_HI     = 2'b10,
        ST_HI_CHK = 2'b11
    } state_e;

    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 2;

endpackage

// File: rtl/sync_chain.sv
// N-stage flop synchroniser for an asynchronous level; all stages clear to 0 on reset.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= d_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect one raw input line; count debounced rising edges.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             async_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic             busy_o
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_debounce
            $error("input_conditioner: DEBOUNCE_CYCLES must be at least 2");
        end
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
            $error("input_conditioner: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic sync_s;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (async_i),
        .q_o   (sync_s)
    );

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] evt_q, evt_d;

    // A candidate change must be seen DEBOUNCE_CYCLES times in a row with en_i high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (en_i && sync_s) begin
                    state_d = ST_LO_CHK;
                    cnt_d   = CW'(1);
                end
            end
            ST_LO_CHK: begin
                if (!en_i || !sync_s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            ST_HI: begin
                if (en_i && !sync_s) begin
                    state_d = ST_HI_CHK;
                    cnt_d   = CW'(1);
                end
            end
            ST_HI_CHK: begin
                if (!en_i || sync_s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Counter follows the registered pulse; clear has priority over increment.
    always_comb begin
        evt_d = evt_q;
        if (clr_i)                      evt_d = '0;
        else if (rise_q && evt_q != '1) evt_d = evt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign evt_cnt_o = evt_q;
    assign busy_o    = (state_q == ST_LO_CHK) || (state_q == ST_HI_CHK);

endmodule
